// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: debug-loaded instruction memory, a PC, and the
// IF/ID register pair. A LOAD/RUN/HALTED mode register gates loading and fetching.
module instruction_fetch_unit #(
    parameter int MEM_DEPTH = 256
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_load_addr,
    input  logic [31:0]                  i_load_data,
    input  logic                         i_start,
    input  logic                         i_enable,
    input  logic                         i_stall,
    input  logic                         i_halt,
    input  logic                         i_jump,
    input  logic [31:0]                  i_jump_address,
    output logic [31:0]                  o_instruction,
    output logic [31:0]                  o_pc,
    output logic [31:0]                  o_pc_current,
    output logic [1:0]                   o_state
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_LOAD   = 2'b00,
        S_RUN    = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] fetch_word;
    logic [31:0] pc_plus4;
    logic        advance;

    // Word index drops the byte offset; upper PC bits alias onto the memory.
    assign fetch_word = mem[pc_q[AW+1:2]];
    assign pc_plus4   = pc_q + 32'd4;
    // Halt, stall and a low enable all block the advance, so a jump is dropped.
    assign advance    = (state_q == S_RUN) && i_enable && !i_halt && !i_stall;

    // Instruction memory: written only while loading, never cleared by reset.
    always_ff @(posedge i_clk) begin
        if (state_q == S_LOAD && i_load_en)
            mem[i_load_addr] <= i_load_data;
    end

    // Next-state logic for the mode register, PC and IF/ID registers.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        case (state_q)
            S_LOAD: begin
                if (i_start)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (advance) begin
                    if_pc_d = pc_plus4;
                    if (i_jump) begin
                        // Wrong-path word is squashed; a HALT here is flushed too.
                        instr_d = NOP_WORD;
                        pc_d    = i_jump_address;
                    end else begin
                        instr_d = fetch_word;
                        if (fetch_word == HALT_WORD)
                            state_d = S_HALTED;   // PC parks on the HALT word
                        else
                            pc_d = pc_plus4;
                    end
                end
            end
            S_HALTED: ;
            default: state_d = S_LOAD;
        endcase
    end

    // Register update with asynchronous active-low clear.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_LOAD;
            pc_q    <= 32'd0;
            instr_q <= NOP_WORD;
            if_pc_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_pc          = if_pc_q;
    assign o_pc_current  = pc_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random control
// traffic, all checked against a word-level reference model.
module tb_instruction_fetch_unit;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_load_en;
    logic [AW-1:0] i_load_addr;
    logic [31:0]   i_load_data;
    logic          i_start, i_enable, i_stall, i_halt, i_jump;
    logic [31:0]   i_jump_address;
    logic [31:0]   o_instruction, o_pc, o_pc_current;
    logic [1:0]    o_state;

    always #5 i_clk = ~i_clk;

    instruction_fetch_unit #(.MEM_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .i_start(i_start), .i_enable(i_enable), .i_stall(i_stall), .i_halt(i_halt),
        .i_jump(i_jump), .i_jump_address(i_jump_address),
        .o_instruction(o_instruction), .o_pc(o_pc),
        .o_pc_current(o_pc_current), .o_state(o_state)
    );

    // Reference model: mode 0=load, 1=run, 2=halted
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_instr, m_opc;
    int          m_state;
    logic [31:0] w [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_instr"}, o_instruction, m_instr);
        chk({tag, "_pc"}, o_pc, m_opc);
        chk({tag, "_pccur"}, o_pc_current, m_pc);
        chk({tag, "_state"}, {30'd0, o_state}, m_state);
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_opc = 0; m_state = 0;
    endtask

    // One rising edge of the spec's rules, applied to the pre-edge inputs.
    task automatic model_edge();
        logic [31:0] word;
        if (m_state == 0) begin
            if (i_load_en) m_mem[i_load_addr] = i_load_data;
            if (i_start) m_state = 1;
        end else if (m_state == 1 && i_enable && !i_halt && !i_stall) begin
            m_opc = m_pc + 32'd4;
            if (i_jump) begin
                m_instr = 0;
                m_pc    = i_jump_address;
            end else begin
                word    = m_mem[(m_pc >> 2) % DEPTH];
                m_instr = word;
                if (word == HALT) m_state = 2;
                else m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic idle();
        i_load_en = 0; i_load_addr = '0; i_load_data = 0; i_start = 0;
        i_enable = 0; i_stall = 0; i_halt = 0; i_jump = 0; i_jump_address = 0;
    endtask

    task automatic step(input string tag);
        @(posedge i_clk);
        model_edge();
        #1;
        chk_outs(tag);
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        i_load_en = 1; i_load_addr = addr[AW-1:0]; i_load_data = data;
        step("load");
        i_load_en = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2;
        i_reset = 0;
        #1;
        model_reset();
        chk_outs(tag);
        idle();
        #1;
        i_reset = 1;
    endtask

    initial begin
        idle();
        i_reset = 0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        #12;
        chk_outs("reset");
        i_reset = 1;

        // Fill memory in LOAD; A..D at words 0..3
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = $urandom & 32'h7FFF_FFFF;
            load_word(i, w[i]);
        end
        i_start = 1; step("start"); i_start = 0;
        chk("start_state", {30'd0, o_state}, 32'd1);

        // Sequential fetch of A,B,C,D
        i_enable = 1;
        for (int k = 0; k < 4; k++) begin
            step("seq");
            chk("seq_word", o_instruction, w[k]);
            chk("seq_opc", o_pc, 32'(4 * (k + 1)));
        end

        // Async reset mid-run; memory survives, restart refetches from 0
        async_reset("arst1");
        i_start = 1; step("restart"); i_start = 0;
        i_enable = 1;
        step("refetch0");
        chk("refetch_a", o_instruction, w[0]);
        step("refetch1");
        chk("refetch_b", o_instruction, w[1]);

        // Jump to 0x20 while o_pc = 8
        i_jump = 1; i_jump_address = 32'h20;
        step("jump");
        chk("jump_nop", o_instruction, 32'd0);
        chk("jump_opc", o_pc, 32'd12);
        chk("jump_pccur", o_pc_current, 32'h20);
        i_jump = 0;
        step("post_jump");
        chk("post_jump_word", o_instruction, w[8]);

        // Stall with jump held: frozen, jump dropped
        i_stall = 1; i_jump = 1; i_jump_address = 32'h4;
        step("stall1");
        step("stall2");
        chk("stall_pccur", o_pc_current, 32'h24);
        i_stall = 0; i_jump = 0;
        step("resume");
        chk("resume_word", o_instruction, w[9]);

        // Step mode: one-cycle pulses every third cycle, one pulse halted
        i_enable = 0;
        for (int p = 0; p < 4; p++) begin
            i_enable = 1; i_halt = (p == 2);
            step("pulse");
            i_enable = 0; i_halt = 0;
            step("gap1");
            step("gap2");
        end

        // PC wrap at the top of the address space
        i_enable = 1; i_jump = 1; i_jump_address = 32'hFFFF_FFFC;
        step("jtop");
        i_jump = 0;
        step("wrap");
        chk("wrap_pccur", o_pc_current, 32'd0);
        chk("wrap_opc", o_pc, 32'd0);
        chk("wrap_word", o_instruction, w[15]);

        // Random control traffic in RUN
        for (int c = 0; c < 400; c++) begin
            i_enable  = ($urandom_range(0, 3) != 0);
            i_stall   = ($urandom_range(0, 4) == 0);
            i_halt    = ($urandom_range(0, 6) == 0);
            i_jump    = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: i_jump_address = $urandom;
                1: i_jump_address = 32'hFFFF_FFF8;
                default: i_jump_address = $urandom_range(0, 4 * DEPTH - 1);
            endcase
            i_load_en   = $urandom_range(0, 1);
            i_load_addr = AW'($urandom);
            i_load_data = $urandom;
            step("rand");
        end
        idle();

        // HALT word at index 2; a jump on the HALT fetch flushes it
        async_reset("arst2");
        load_word(2, HALT);
        i_start = 1; step("start2"); i_start = 0;
        i_enable = 1;
        step("h0");
        step("h1");
        i_jump = 1; i_jump_address = 32'h0;
        step("hflush");
        chk("hflush_state", {30'd0, o_state}, 32'd1);
        chk("hflush_nop", o_instruction, 32'd0);
        i_jump = 0;
        step("h2");
        step("h3");
        step("h4");
        chk("halt_word", o_instruction, HALT);
        chk("halt_state", {30'd0, o_state}, 32'd2);
        chk("halt_opc", o_pc, 32'd12);

        // HALTED is sticky; loads, jumps and enables are ignored
        for (int c = 0; c < 20; c++) begin
            i_enable = $urandom_range(0, 1);
            i_jump = $urandom_range(0, 1); i_jump_address = $urandom;
            i_start = $urandom_range(0, 1);
            i_load_en = 1; i_load_addr = AW'(c % 4); i_load_data = 32'h0;
            step("halted");
            chk("halted_pccur", o_pc_current, 32'd8);
        end
        idle();

        // After reset the HALT word is still in memory
        async_reset("arst3");
        i_start = 1; step("start3"); i_start = 0;
        i_enable = 1;
        step("r0");
        step("r1");
        step("r2");
        chk("mem_kept_halt", o_instruction, HALT);
        chk("mem_kept_word0", m_mem[0], w[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
